ro_sample_engine: RTL and testbench
===================================

Name: ro_sample_engine

Overview:
Next-generation ring-oscillator sampling engine. It drives N_BANKS ring-oscillator counter banks with a per-bank enable mask and runs timed clear/collect/settle/latch sample windows. Each window produces a saturating masked sum, which is emitted on a valid/ready stream tagged with a sample index. Supports one-shot and continuous modes, counts samples dropped under backpressure, and sits between the RO bank array and the result FIFO.

Parameters:
N_BANKS, 4, number of RO counter banks
CNT_WIDTH, 14, width of each bank count
SUM_WIDTH, 16, output sum width; true sum saturates at 2**SUM_WIDTH-1
NUM_SAMPLE_WIDTH, 16, width of sample count and index
COLLECT_WIDTH, 10, width of collect-window length
SETTLE_CYCLES, 2, wait cycles after disable before latching (ripple settle)
DROP_WIDTH, 16, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
go  in  1  start request (level)
stop  in  1  abort request
cfg_continuous  in  1  1 = run until stop, ignore cfg_num_samples
cfg_bank_mask  in  N_BANKS  banks included in enable and sum
cfg_num_samples  in  NUM_SAMPLE_WIDTH  samples per one-shot run
cfg_collect_cycles  in  COLLECT_WIDTH  enable-window length in cycles
roc_rst  out  1  clear to all RO counters
roc_en  out  N_BANKS  per-bank RO enable
roc_cnt  in  N_BANKS*CNT_WIDTH  bank counts, bank i at [i*CNT_WIDTH +: CNT_WIDTH]
out_valid  out  1  result valid
out_ready  in  1  consumer accept
out_data  out  SUM_WIDTH  masked saturated sum
out_index  out  NUM_SAMPLE_WIDTH  sample index of out_data
out_sat  out  1  out_data saturated
busy  out  1  state not IDLE/DONE
done  out  1  run finished (level)
drop_count  out  DROP_WIDTH  samples lost to backpressure, saturating

Behaviour:
- Reset values:
  - roc_rst=1; roc_en=0; out_valid=0; out_data=0; out_index=0; out_sat=0; busy=0; done=0; drop_count=0.
  - State goes to IDLE immediately on rst, including mid-run.
- States: IDLE, CLEAR, COLLECT, SETTLE, LATCH, DONE.
- IDLE:
  - roc_rst=1.
  - On go: latch all cfg_* inputs, clear drop_count and the sample index, go to CLEAR.
  - Exception: one-shot with cfg_num_samples=0 goes directly to DONE.
- CLEAR: 1 cycle; roc_rst=1; load collect counter (0 treated as 1).
- COLLECT:
  - roc_en = latched mask for exactly max(cfg_collect_cycles,1) cycles, registered output.
  - Then go to SETTLE.
- SETTLE: roc_en=0 for SETTLE_CYCLES cycles (0 means skip), then LATCH.
- LATCH: 1 cycle; register the sum of masked banks, computed at full width CNT_WIDTH+$clog2(N_BANKS).
  - If the sum exceeds 2**SUM_WIDTH-1: clamp to all ones, sat=1.
  - Next state is CLEAR, or DONE when one-shot and the index reaches cfg_num_samples.
- Sample period = 3+collect+SETTLE_CYCLES cycles.
- Output slot (single entry):
  - The result is loaded the cycle after LATCH: out_valid=1, out_index=sample index.
  - If out_valid=1 and out_ready=0 at that load point: keep the old entry, drop the new sample, drop_count+1 (saturating).
  - If out_valid&out_ready coincides with the load: accept the old entry and load the new one, no drop.
  - The index increments per LATCH whether or not the sample is dropped; it wraps modulo 2**NUM_SAMPLE_WIDTH.
  - Sampling never stalls, which preserves window timing.
- stop:
  - In CLEAR/COLLECT/SETTLE/LATCH, stop forces next state DONE.
  - A window cut short by stop is discarded and never emitted.
  - An already-valid output entry stays until accepted.
  - roc_en=0 from the next cycle.
- stop and LATCH completion in the same cycle: the sample is emitted, then DONE.
- DONE:
  - done=1 and roc_rst=1 until go=0, then IDLE.
  - go held high in DONE does not restart.
- go while busy: ignored.
- cfg_* changes while busy: ignored.
- busy=1 in CLEAR..LATCH.

Decomposition:
- Package ro_pkg holds:
  - state_t enum (IDLE, CLEAR, COLLECT, SETTLE, LATCH, DONE);
  - mode typedef (ONE_SHOT, CONTINUOUS);
  - a function computing sum width from CNT_WIDTH and N_BANKS.
- Sub-module ro_masked_sum:
  - inputs: roc_cnt, mask;
  - outputs: saturated SUM_WIDTH sum and sat flag;
  - combinational, registered by the parent in LATCH.

Test Plan:
1. One-shot, num_samples=3, collect=5, mask=4'b1111, all counts 100, out_ready=1 -> three outputs data=400 at index 0,1,2, spaced 10 cycles apart; done=1; drop_count=0.
2. mask=4'b0101, counts 10/20/30/40 -> roc_en only bits 0 and 2 high for exactly 5 cycles; out_data=40.
3. SUM_WIDTH=15, all counts 16383 -> out_data=32767, out_sat=1; counts 1000 -> out_data=4000, out_sat=0.
4. Continuous, collect=5, out_ready=0 across three LATCHes, then 1 -> index 0 held, drop_count=2; next accepted out_index=3.
5. stop asserted in COLLECT of sample 1 in one-shot run of 4 -> only index 0 emitted; roc_en=0 next cycle; done=1 until go drops.
6. rst pulsed mid-COLLECT -> all outputs at reset values immediately; new go restarts at out_index=0 with drop_count=0.

Source files
------------

// File: rtl/ro_pkg.sv
// Shared types and helpers for the ring-oscillator sampling engine.
package ro_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      COLLECT,
      SETTLE,
      LATCH,
      DONE
   } state_t;

   typedef enum logic {
      ONE_SHOT,
      CONTINUOUS
   } mode_t;

   // Width needed to add n_banks counts of cnt_width bits without overflow.
   function automatic int unsigned full_sum_width(int unsigned cnt_width, int unsigned n_banks);
      return cnt_width + $clog2(n_banks);
   endfunction

endpackage

// File: rtl/ro_masked_sum.sv
// Combinational masked sum of all RO bank counts, saturated to SUM_WIDTH bits.
module ro_masked_sum
   import ro_pkg::*;
#(
   parameter int unsigned N_BANKS   = 4,
   parameter int unsigned CNT_WIDTH = 14,
   parameter int unsigned SUM_WIDTH = 16
) (
   input  logic [N_BANKS*CNT_WIDTH-1:0] roc_cnt,
   input  logic [N_BANKS-1:0]           mask,
   output logic [SUM_WIDTH-1:0]         sum,
   output logic                         sat
);

   localparam int unsigned FullW = full_sum_width(CNT_WIDTH, N_BANKS);

   logic [FullW-1:0] full;

   always_comb begin
      full = '0;
      for (int i = 0; i < N_BANKS; i++) begin
         if (mask[i]) begin
            full = full + FullW'(roc_cnt[i*CNT_WIDTH +: CNT_WIDTH]);
         end
      end
   end

   if (FullW > SUM_WIDTH) begin : g_sat
      assign sat = |full[FullW-1:SUM_WIDTH];
      assign sum = sat ? '1 : full[SUM_WIDTH-1:0];
   end else begin : g_nosat
      assign sat = 1'b0;
      assign sum = SUM_WIDTH'(full);
   end

endmodule

// File: rtl/ro_sample_engine.sv
// Ring-oscillator sampling engine: timed clear/collect/settle/latch windows feeding a
// single-entry valid/ready result slot with drop counting under backpressure.
module ro_sample_engine
   import ro_pkg::*;
#(
   parameter int unsigned N_BANKS          = 4,
   parameter int unsigned CNT_WIDTH        = 14,
   parameter int unsigned SUM_WIDTH        = 16,
   parameter int unsigned NUM_SAMPLE_WIDTH = 16,
   parameter int unsigned COLLECT_WIDTH    = 10,
   parameter int unsigned SETTLE_CYCLES    = 2,
   parameter int unsigned DROP_WIDTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   input  logic                          stop,
   input  logic                          cfg_continuous,
   input  logic [N_BANKS-1:0]            cfg_bank_mask,
   input  logic [NUM_SAMPLE_WIDTH-1:0]   cfg_num_samples,
   input  logic [COLLECT_WIDTH-1:0]      cfg_collect_cycles,
   output logic                          roc_rst,
   output logic [N_BANKS-1:0]            roc_en,
   input  logic [N_BANKS*CNT_WIDTH-1:0]  roc_cnt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SUM_WIDTH-1:0]          out_data,
   output logic [NUM_SAMPLE_WIDTH-1:0]   out_index,
   output logic                          out_sat,
   output logic                          busy,
   output logic                          done,
   output logic [DROP_WIDTH-1:0]         drop_count
);

   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SettleLoad = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
   localparam state_t AfterCollect = (SETTLE_CYCLES == 0) ? LATCH : SETTLE;

   state_t                      state_q;
   mode_t                       mode_q;
   logic [N_BANKS-1:0]          mask_q;
   logic [NUM_SAMPLE_WIDTH-1:0] num_q;
   logic [COLLECT_WIDTH-1:0]    coll_q;
   logic [COLLECT_WIDTH-1:0]    win_cnt_q;
   logic [SW-1:0]               settle_cnt_q;
   logic [NUM_SAMPLE_WIDTH-1:0] idx_q;
   logic [NUM_SAMPLE_WIDTH-1:0] idx_inc;
   logic [N_BANKS-1:0]          roc_en_q;
   logic [SUM_WIDTH-1:0]        lat_data_q;
   logic                        lat_sat_q;
   logic [NUM_SAMPLE_WIDTH-1:0] lat_idx_q;
   logic                        pend_q;
   logic                        out_valid_q;
   logic [SUM_WIDTH-1:0]        out_data_q;
   logic [NUM_SAMPLE_WIDTH-1:0] out_index_q;
   logic                        out_sat_q;
   logic [DROP_WIDTH-1:0]       drop_q;
   logic [SUM_WIDTH-1:0]        sum;
   logic                        sat;
   logic                        start;

   ro_masked_sum #(
      .N_BANKS   (N_BANKS),
      .CNT_WIDTH (CNT_WIDTH),
      .SUM_WIDTH (SUM_WIDTH)
   ) u_sum (
      .roc_cnt (roc_cnt),
      .mask    (mask_q),
      .sum     (sum),
      .sat     (sat)
   );

   assign idx_inc = idx_q + 1'b1;
   assign start   = (state_q == IDLE) && go;

   // COLLECT lasts collect+1 cycles: the first loads roc_en, so the enable is high for
   // exactly collect cycles and drops on the first SETTLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= ONE_SHOT;
         mask_q       <= '0;
         num_q        <= '0;
         coll_q       <= '0;
         win_cnt_q    <= '0;
         settle_cnt_q <= '0;
         idx_q        <= '0;
         roc_en_q     <= '0;
         lat_data_q   <= '0;
         lat_sat_q    <= 1'b0;
         lat_idx_q    <= '0;
         pend_q       <= 1'b0;
      end else begin
         roc_en_q <= '0;
         pend_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  mode_q <= cfg_continuous ? CONTINUOUS : ONE_SHOT;
                  mask_q <= cfg_bank_mask;
                  num_q  <= cfg_num_samples;
                  coll_q <= cfg_collect_cycles;
                  idx_q  <= '0;
                  if (!cfg_continuous && (cfg_num_samples == '0)) state_q <= DONE;
                  else                                             state_q <= CLEAR;
               end
            end
            CLEAR: begin
               win_cnt_q <= (coll_q == '0) ? COLLECT_WIDTH'(1) : coll_q;
               state_q   <= stop ? DONE : COLLECT;
            end
            COLLECT: begin
               if (stop) begin
                  state_q <= DONE;
               end else if (win_cnt_q != '0) begin
                  roc_en_q  <= mask_q;
                  win_cnt_q <= win_cnt_q - 1'b1;
               end else begin
                  settle_cnt_q <= SettleLoad;
                  state_q      <= AfterCollect;
               end
            end
            SETTLE: begin
               if (stop)                     state_q <= DONE;
               else if (settle_cnt_q == '0)  state_q <= LATCH;
               else                          settle_cnt_q <= settle_cnt_q - 1'b1;
            end
            LATCH: begin
               lat_data_q <= sum;
               lat_sat_q  <= sat;
               lat_idx_q  <= idx_q;
               pend_q     <= 1'b1;
               idx_q      <= idx_inc;
               if (stop || ((mode_q == ONE_SHOT) && (idx_inc == num_q))) state_q <= DONE;
               else                                                       state_q <= CLEAR;
            end
            DONE: begin
               if (!go) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Single-entry result slot; a new sample never waits, it is dropped instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_sat_q   <= 1'b0;
         drop_q      <= '0;
      end else if (start) begin
         drop_q <= '0;
         if (out_ready) out_valid_q <= 1'b0;
      end else if (pend_q) begin
         if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lat_data_q;
            out_index_q <= lat_idx_q;
            out_sat_q   <= lat_sat_q;
         end else if (drop_q != '1) begin
            drop_q <= drop_q + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign roc_rst    = (state_q == IDLE) || (state_q == CLEAR) || (state_q == DONE);
   assign roc_en     = roc_en_q;
   assign busy       = (state_q == CLEAR) || (state_q == COLLECT) || (state_q == SETTLE) ||
                       (state_q == LATCH);
   assign done       = (state_q == DONE);
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_index  = out_index_q;
   assign out_sat    = out_sat_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_ro_sample_engine.sv
// Directed bench for ro_sample_engine with SUM_WIDTH=15 so saturation is reachable.
module tb_ro_sample_engine;

   localparam int NB = 4;
   localparam int CW = 14;
   localparam int SUMW = 15;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           go = 1'b0;
   logic           stop = 1'b0;
   logic           cfg_continuous = 1'b0;
   logic [NB-1:0]  cfg_bank_mask = '0;
   logic [15:0]    cfg_num_samples = '0;
   logic [9:0]     cfg_collect_cycles = '0;
   logic           roc_rst;
   logic [NB-1:0]  roc_en;
   logic [NB*CW-1:0] roc_cnt = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [SUMW-1:0] out_data;
   logic [15:0]    out_index;
   logic           out_sat;
   logic           busy;
   logic           done;
   logic [15:0]    drop_count;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ro_sample_engine #(
      .N_BANKS          (NB),
      .CNT_WIDTH        (CW),
      .SUM_WIDTH        (SUMW),
      .NUM_SAMPLE_WIDTH (16),
      .COLLECT_WIDTH    (10),
      .SETTLE_CYCLES    (2),
      .DROP_WIDTH       (16)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .go                 (go),
      .stop               (stop),
      .cfg_continuous     (cfg_continuous),
      .cfg_bank_mask      (cfg_bank_mask),
      .cfg_num_samples    (cfg_num_samples),
      .cfg_collect_cycles (cfg_collect_cycles),
      .roc_rst            (roc_rst),
      .roc_en             (roc_en),
      .roc_cnt            (roc_cnt),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_data           (out_data),
      .out_index          (out_index),
      .out_sat            (out_sat),
      .busy               (busy),
      .done               (done),
      .drop_count         (drop_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_counts(input int a, input int b, input int c, input int d);
      roc_cnt = {CW'(d), CW'(c), CW'(b), CW'(a)};
   endtask

   task automatic wait_valid(input string tag, input int budget);
      for (int i = 0; i < budget && !out_valid; i++) tick();
      check(tag, out_valid, 1);
   endtask

   task automatic finish_run(input string tag);
      for (int i = 0; i < 60 && !done; i++) tick();
      check(tag, done, 1);
      go = 1'b0;
      tick();
      tick();
      check({tag, "_idle"}, done, 0);
   endtask

   int t_prev;
   int en_cycles;
   int en_bad;
   int n_valid;

   initial begin
      // Reset state
      #2;
      check("rst_roc_rst", roc_rst, 1);
      check("rst_roc_en", roc_en, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_drop", drop_count, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 1: one-shot, 3 samples of 4x100
      cfg_continuous = 1'b0; cfg_bank_mask = 4'b1111; cfg_num_samples = 16'd3;
      cfg_collect_cycles = 10'd5; set_counts(100, 100, 100, 100); out_ready = 1'b1;
      go = 1'b1;
      tick();
      check("t1_busy", busy, 1);
      t_prev = 0;
      for (int s = 0; s < 3; s++) begin
         wait_valid("t1_valid", 40);
         check("t1_data", out_data, 400);
         check("t1_index", out_index, s);
         check("t1_sat", out_sat, 0);
         if (s > 0) check("t1_spacing", cyc - t_prev, 10);
         t_prev = cyc;
         tick();
      end
      check("t1_drop", drop_count, 0);
      for (int i = 0; i < 5; i++) tick();
      check("t1_done_held", done, 1);
      finish_run("t1_done");

      // 2: partial mask, enable pattern and masked sum
      cfg_bank_mask = 4'b0101; cfg_num_samples = 16'd1; set_counts(10, 20, 30, 40);
      go = 1'b1;
      en_cycles = 0; en_bad = 0;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         tick();
         if (roc_en != 4'b0000) begin
            en_cycles++;
            if (roc_en != 4'b0101) en_bad++;
         end
      end
      check("t2_valid", out_valid, 1);
      check("t2_en_cycles", en_cycles, 5);
      check("t2_en_bad", en_bad, 0);
      check("t2_data", out_data, 40);
      check("t2_index", out_index, 0);
      finish_run("t2_done");

      // 3: saturation then a non-saturating sum
      cfg_bank_mask = 4'b1111; set_counts(16383, 16383, 16383, 16383);
      go = 1'b1;
      wait_valid("t3a_valid", 40);
      check("t3a_data", out_data, 32767);
      check("t3a_sat", out_sat, 1);
      finish_run("t3a_done");
      set_counts(1000, 1000, 1000, 1000);
      go = 1'b1;
      wait_valid("t3b_valid", 40);
      check("t3b_data", out_data, 4000);
      check("t3b_sat", out_sat, 0);
      finish_run("t3b_done");

      // 4: continuous with backpressure over three latches
      cfg_continuous = 1'b1; set_counts(100, 100, 100, 100); out_ready = 1'b0;
      go = 1'b1;
      wait_valid("t4_valid0", 40);
      check("t4_index0", out_index, 0);
      for (int i = 0; i < 25; i++) tick();
      check("t4_held_valid", out_valid, 1);
      check("t4_held_index", out_index, 0);
      check("t4_drop", drop_count, 2);
      out_ready = 1'b1;
      tick();
      check("t4_accepted", out_valid, 0);
      wait_valid("t4_valid3", 20);
      check("t4_index3", out_index, 3);
      check("t4_drop_after", drop_count, 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      finish_run("t4_done");

      // 5: stop during COLLECT of sample 1
      cfg_continuous = 1'b0; cfg_num_samples = 16'd4;
      go = 1'b1;
      wait_valid("t5_valid0", 40);
      check("t5_index0", out_index, 0);
      tick();
      tick();
      check("t5_en_before", roc_en, 4'hf);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t5_en_after", roc_en, 0);
      check("t5_done", done, 1);
      check("t5_busy", busy, 0);
      n_valid = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid) n_valid++;
      end
      check("t5_no_emit", n_valid, 0);
      check("t5_done_held", done, 1);
      go = 1'b0;
      tick();
      check("t5_idle", done, 0);

      // 6: asynchronous reset mid-COLLECT, then restart
      cfg_continuous = 1'b1; out_ready = 1'b0;
      go = 1'b1;
      wait_valid("t6_valid0", 40);
      for (int i = 0; i < 12; i++) tick();
      check("t6_drop_pre", drop_count, 1);
      check("t6_en_pre", roc_en, 4'hf);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_en", roc_en, 0);
      check("t6_rst_roc_rst", roc_rst, 1);
      check("t6_rst_drop", drop_count, 0);
      check("t6_rst_index", out_index, 0);
      check("t6_rst_busy", busy, 0);
      go = 1'b0; out_ready = 1'b1; cfg_continuous = 1'b0; cfg_num_samples = 16'd1;
      @(negedge clk);
      rst = 1'b0;
      tick();
      go = 1'b1;
      wait_valid("t6_valid_new", 40);
      check("t6_index_new", out_index, 0);
      check("t6_data_new", out_data, 400);
      check("t6_drop_new", drop_count, 0);
      finish_run("t6_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
